fetch_prefetch_unit: RTL and testbench
======================================

# fetch_prefetch_unit

Parametrised fetch stage that replaces the single-cycle PC/instruction-memory path with a pipelined, prefetching front end. It keeps a fetch PC, issues sequential requests to an instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Decode drains the FIFO through a valid/ready interface. A redirect from execute (taken branch or jump) flushes the FIFO and discards in-flight responses.

## Interface
- DATA_WIDTH, 32, instruction width
- ADDR_WIDTH, 32, PC and memory address width
- DEPTH, 4, FIFO entries and maximum in-flight requests; power of 2, at least 2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-low: 0 = reset
- redirect_i  in  1  take redirect_target_i this cycle
- redirect_target_i  in  ADDR_WIDTH  new PC; bits [1:0] ignored and treated as 0
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  ADDR_WIDTH  fetch address, word aligned
- imem_gnt_i  in  1  request accepted when imem_req_o && imem_gnt_i
- imem_rvalid_i  in  1  response valid; in order, at least 1 cycle after its grant
- imem_rdata_i  in  DATA_WIDTH  response instruction
- instr_valid_o  out  1  FIFO head valid
- instr_o  out  DATA_WIDTH  FIFO head instruction
- instr_pc_o  out  ADDR_WIDTH  PC of instr_o
- instr_ready_i  in  1  decode accepts head when instr_valid_o && instr_ready_i

## Operation
- Registers: fetch_pc, ret_pc (PC of the next accepted response), FIFO (DEPTH × {instr, pc}) with read/write pointers and count, outstanding counter, discard counter. Counters are $clog2(DEPTH+1) bits.
- Issue: imem_req_o = !redirect_i && (outstanding + count < DEPTH). imem_addr_o = fetch_pc.
  - On a grant, fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH) and outstanding increments.
  - Address is held stable until granted.
- Response: on imem_rvalid_i, outstanding decrements.
  - If discard > 0: discard decrements and the data is dropped.
  - Otherwise push {imem_rdata_i, ret_pc} and ret_pc += 4.
- Pop: on instr_valid_o && instr_ready_i, read pointer advances. Simultaneous push and pop leaves count unchanged. The credit rule prevents overflow, so a push is never lost.
- Redirect has priority over everything:
  - FIFO is flushed (count = 0, pointers = 0) and any pop in the same cycle is ignored.
  - fetch_pc and ret_pc load {target[ADDR_WIDTH-1:2], 2'b00}.
  - discard loads the in-flight count: outstanding, minus 1 if imem_rvalid_i is high this cycle.
  - A response arriving in the redirect cycle is dropped.
  - A second redirect during discard reloads discard using the same rule.
- Mode view: RUN when discard == 0, FLUSH when discard > 0.
  - New requests are permitted in FLUSH.
  - Ordering guarantees that the first discard responses are stale.
- Reset (rst == 0): fetch_pc = ret_pc = RESET_PC; count, pointers, outstanding and discard = 0.

## Timing
- Reset values:
  - imem_req_o = 0 and instr_valid_o = 0 while rst == 0.
  - imem_addr_o = RESET_PC.
  - instr_o and instr_pc_o are don't-care while invalid.
- First request: imem_req_o = 1 with address RESET_PC in the first cycle after rst returns high.
- Latency: grant at cycle t, rvalid at t+k (k ≥ 1), instr_valid_o at t+k+1. With a zero-wait memory (gnt held at 1, k = 1), the FIFO sustains 1 instruction/cycle.
- Redirect at cycle t:
  - imem_req_o = 0 at t.
  - Request to the target is issued at t+1.
  - instr_valid_o = 0 at t+1.
  - The first target instruction is valid no earlier than t+3.
- Full: count == DEPTH with decode stalled gives imem_req_o = 0. Request resumes the cycle after a pop frees a credit.
- Reset mid-operation: all state clears next edge. Responses still arriving after reset from pre-reset grants are memory's responsibility; the memory must be reset with the fetch unit.
- Outputs instr_o and instr_pc_o come from FIFO registers. There is no combinational path from imem_rdata_i.

## Test plan
- Reset release, gnt = 1, k = 1, ready = 1:
  - Requests to 0x0, 0x4, 0x8, … on consecutive cycles.
  - instr_pc_o = 0x0 at cycle 3 after release, then +4 per cycle with matching instr_o.
- Decode stalled (ready = 0), DEPTH = 4:
  - Exactly 4 grants, then imem_req_o = 0 with count = 4.
  - Raising ready pops PCs 0x0..0xC in order and resumes requests one cycle after the first pop.
- Redirect to 0x104 with 2 requests in flight:
  - Redirect cycle shows imem_req_o = 0; next request address is 0x104.
  - Both stale responses are dropped.
  - First valid output has instr_pc_o = 0x104.
- Redirect coinciding with rvalid and a pop:
  - The response and the pop are both discarded.
  - discard = outstanding − 1.
  - No stale instruction reaches the output.
- Random gnt/rvalid delays (k = 1..5) with back-to-back redirects:
  - The scoreboard sees only target-sequential PCs, with no loss or duplication.
  - outstanding never exceeds DEPTH − count.
- Reset asserted mid-stream:
  - instr_valid_o = 0 and imem_req_o = 0 in the next cycle.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Prefetching fetch stage: issues sequential instruction-memory requests under a
// credit limit, buffers responses with their PCs and hands them to decode.
module fetch_prefetch_unit #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_target_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } mode_t;

    logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_n;
    logic [ADDR_WIDTH-1:0] ret_pc, ret_pc_n;
    logic [CW-1:0]         count, count_n;
    logic [CW-1:0]         outstanding, outstanding_n;
    logic [CW-1:0]         discard, discard_n;
    logic [PW-1:0]         wptr, wptr_n;
    logic [PW-1:0]         rptr, rptr_n;

    logic [DATA_WIDTH-1:0] fifo_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc    [DEPTH];

    mode_t                 mode;
    logic [ADDR_WIDTH-1:0] target;
    logic [CW:0]           credit_used;
    logic                  grant;
    logic                  push;
    logic                  pop;

    // Low target bits are masked rather than sliced so every input bit stays in use.
    assign target      = redirect_target_i & ~ADDR_WIDTH'(3);
    assign credit_used = {1'b0, outstanding} + {1'b0, count};

    always_comb begin
        mode = (discard == '0) ? RUN : FLUSH;
    end

    always_comb begin
        imem_req_o    = rst && !redirect_i && (credit_used < (CW + 1)'(DEPTH));
        imem_addr_o   = rst ? fetch_pc : RESET_PC;
        instr_valid_o = rst && (count != '0);
        instr_o       = fifo_instr[rptr];
        instr_pc_o    = fifo_pc[rptr];
        grant         = imem_req_o && imem_gnt_i;
        push          = imem_rvalid_i && !redirect_i && (mode == RUN);
        pop           = instr_valid_o && instr_ready_i && !redirect_i;
    end

    always_comb begin
        fetch_pc_n    = fetch_pc;
        ret_pc_n      = ret_pc;
        count_n       = count;
        wptr_n        = wptr;
        rptr_n        = rptr;
        outstanding_n = outstanding + CW'(grant) - CW'(imem_rvalid_i);
        discard_n     = discard;

        if (redirect_i) begin
            fetch_pc_n = target;
            ret_pc_n   = target;
            count_n    = '0;
            wptr_n     = '0;
            rptr_n     = '0;
            // Responses still owed after this cycle are all stale.
            discard_n  = outstanding - CW'(imem_rvalid_i);
        end else begin
            if (grant) begin
                fetch_pc_n = fetch_pc + ADDR_WIDTH'(4);
            end
            if (imem_rvalid_i && (mode == FLUSH)) begin
                discard_n = discard - CW'(1);
            end
            if (push) begin
                ret_pc_n = ret_pc + ADDR_WIDTH'(4);
                wptr_n   = wptr + PW'(1);
            end
            if (pop) begin
                rptr_n = rptr + PW'(1);
            end
            count_n = count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            ret_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            wptr        <= '0;
            rptr        <= '0;
        end else begin
            fetch_pc    <= fetch_pc_n;
            ret_pc      <= ret_pc_n;
            count       <= count_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
            wptr        <= wptr_n;
            rptr        <= rptr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo_instr[wptr] <= imem_rdata_i;
            fifo_pc[wptr]    <= ret_pc;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized scoreboard bench for fetch_prefetch_unit with an in-order
// variable-latency instruction memory and an epoch-based model of stale responses.
module tb_fetch_prefetch_unit;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [AW-1:0] RPC = 32'h0000_0000;

    logic          clk;
    logic          rst;
    logic          redirect_i;
    logic [AW-1:0] redirect_target_i;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_gnt_i;
    logic          imem_rvalid_i;
    logic [DW-1:0] imem_rdata_i;
    logic          instr_valid_o;
    logic [DW-1:0] instr_o;
    logic [AW-1:0] instr_pc_o;
    logic          instr_ready_i;

    fetch_prefetch_unit #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect_i(redirect_i),
        .redirect_target_i(redirect_target_i),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_o(instr_o),
        .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        int unsigned   epoch;
        int unsigned   due;
    } mreq_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } exp_t;

    mreq_t mq[$];
    exp_t  eq[$];

    int unsigned total = 0, passed = 0;
    int unsigned cyc = 0, last_due = 0, epoch = 0;
    int          infl = 0, fcount = 0;
    logic [AW-1:0] mpc = RPC;

    int unsigned gnt_pct = 100, ready_pct = 100, redir_pct = 0, kmin = 1, kmax = 1;
    bit          coinc = 1'b0;
    bit          force_redir = 1'b0;
    logic [AW-1:0] force_tgt = '0;
    int unsigned grants = 0, dut_pops = 0;
    bit          mon_seen = 1'b0;
    logic [AW-1:0] mon_first_pc = '0;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic do_reset(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b0; redirect_i = 1'b0; imem_gnt_i = 1'b0;
            imem_rvalid_i = 1'b0; instr_ready_i = 1'b0;
            #1;
            check(!imem_req_o, "reset_req", 32'(imem_req_o), 0);
            check(!instr_valid_o, "reset_valid", 32'(instr_valid_o), 0);
            if (i > 0) check(imem_addr_o == RPC, "reset_addr", imem_addr_o, RPC);
        end
        mq.delete(); eq.delete();
        infl = 0; fcount = 0; mpc = RPC; epoch++; last_due = 0;
    endtask

    task automatic cycle();
        mreq_t r;
        bit have_resp, redir, grant, fresh, popm;
        logic [AW-1:0] tgt;
        int unsigned k, due;
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        have_resp = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            r = mq.pop_front();
            have_resp = 1'b1;
            imem_rvalid_i = 1'b1;
            imem_rdata_i = memf(r.pc);
        end
        imem_gnt_i    = ($urandom_range(99) < gnt_pct);
        instr_ready_i = ($urandom_range(99) < ready_pct);
        redir = force_redir || ($urandom_range(99) < redir_pct);
        if (coinc && have_resp && fcount > 0 && instr_ready_i && $urandom_range(1) == 1) redir = 1'b1;
        tgt = force_redir ? force_tgt : ($urandom & 32'h0000_0FFF);
        force_redir = 1'b0;
        redirect_i = redir;
        redirect_target_i = tgt;
        #1;
        check(instr_valid_o == (fcount != 0), "valid", 32'(instr_valid_o), 32'(fcount != 0));
        check(imem_req_o == (!redir && (infl + fcount < DEPTH)), "req",
              32'(imem_req_o), 32'(!redir && (infl + fcount < DEPTH)));
        if (imem_req_o) check(imem_addr_o == mpc, "addr", imem_addr_o, mpc);
        if (instr_valid_o && instr_ready_i && !redir) dut_pops++;
        if (redir) begin
            epoch++;
            mpc = tgt & ~32'h3;
            eq.delete();
        end
        grant = imem_req_o && imem_gnt_i;
        if (grant) begin
            k = $urandom_range(kmax, kmin);
            due = cyc + k;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{pc: mpc, epoch: epoch, due: due});
            mpc += 4;
            grants++;
        end
        fresh = have_resp && (r.epoch == epoch);
        if (fresh) eq.push_back('{pc: r.pc, data: memf(r.pc)});
        popm = (fcount > 0) && instr_ready_i && !redir;
        fcount = redir ? 0 : fcount + int'(fresh) - int'(popm);
        infl = infl + int'(grant) - int'(have_resp);
        check(infl + fcount <= DEPTH, "credit", 32'(infl + fcount), DEPTH);
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && instr_valid_o && instr_ready_i && !redirect_i) begin
                if (!mon_seen) begin
                    mon_seen = 1'b1;
                    mon_first_pc = instr_pc_o;
                end
                if (eq.size() == 0) begin
                    check(1'b0, "unexpected_pop", instr_pc_o, 0);
                end else begin
                    e = eq.pop_front();
                    check(instr_pc_o == e.pc, "pop_pc", instr_pc_o, e.pc);
                    check(instr_o == e.data, "pop_instr", instr_o, e.data);
                end
            end
        end
    end

    initial begin : stimulus
        int unsigned n;
        rst = 1'b0; redirect_i = 1'b0; redirect_target_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; instr_ready_i = 1'b0;

        do_reset(3);
        dut_pops = 0;
        run(20);
        check(dut_pops == 18, "zero_wait_throughput", dut_pops, 18);

        do_reset(2);
        ready_pct = 0; grants = 0;
        run(10);
        check(grants == DEPTH, "stall_grants", grants, DEPTH);
        ready_pct = 100;
        run(10);

        do_reset(2);
        kmin = 3; kmax = 3;
        run(2);
        force_redir = 1'b1; force_tgt = 32'h0000_0105;
        mon_seen = 1'b0;
        run(15);
        check(mon_seen && mon_first_pc == 32'h104, "redirect_first_pc", mon_first_pc, 32'h104);

        kmin = 1; kmax = 5; gnt_pct = 70; ready_pct = 70; redir_pct = 4; coinc = 1'b1;
        run(3000);
        do_reset(1);
        gnt_pct = 100; ready_pct = 100; redir_pct = 0; coinc = 1'b0; kmin = 1; kmax = 1;
        mon_seen = 1'b0;
        run(20);
        check(mon_seen && mon_first_pc == RPC, "restart_pc", mon_first_pc, RPC);

        gnt_pct = 0;
        n = 0;
        while ((infl != 0 || fcount != 0) && n < 100) begin
            cycle();
            n++;
        end
        check(infl == 0 && fcount == 0, "drain_timeout", 32'(infl + fcount), 0);
        @(negedge clk);
        #3;
        check(eq.size() == 0, "scoreboard_empty", eq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
